// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access widths, FSM states,
// request payload and byte-mask helpers.
package lsu_pkg;

  localparam int unsigned WdtTypeCnt = 4;
  localparam int unsigned WdtW       = $clog2(WdtTypeCnt);

  typedef enum logic [WdtW-1:0] {
    Wdt8  = 2'd0,
    Wdt16 = 2'd1,
    Wdt32 = 2'd2,
    Wdt64 = 2'd3
  } wdt_e;

  localparam int unsigned LsuAddrW = 64;
  localparam int unsigned LsuDataW = 64;
  localparam int unsigned LsuTagW  = 5;
  localparam int unsigned LsuMaskW = 8;

  localparam logic [LsuMaskW-1:0] MaskWdt8  = 8'h01;
  localparam logic [LsuMaskW-1:0] MaskWdt16 = 8'h03;
  localparam logic [LsuMaskW-1:0] MaskWdt32 = 8'h0F;
  localparam logic [LsuMaskW-1:0] MaskWdt64 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [LsuAddrW-1:0] addr;
    logic [LsuDataW-1:0] wdata;
    logic                ren;
    logic                wen;
    wdt_e                wdt_op;
    logic                sext;
    logic [LsuTagW-1:0]  tag;
  } lsu_req_t;

  function automatic logic [LsuMaskW-1:0] base_mask(input wdt_e w);
    case (w)
      Wdt8:    base_mask = MaskWdt8;
      Wdt16:   base_mask = MaskWdt16;
      Wdt32:   base_mask = MaskWdt32;
      default: base_mask = MaskWdt64;
    endcase
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [2:0] off, input wdt_e w);
    case (w)
      Wdt8:    misaligned = 1'b0;
      Wdt16:   misaligned = off[0];
      Wdt32:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/mask shift onto the doubleword lane and
// load extract with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]          st_off,
  input  logic [DATA_W-1:0]   st_data,
  input  wdt_e                st_wdt,
  output logic [DATA_W-1:0]   st_lane,
  output logic [LsuMaskW-1:0] st_mask,
  input  logic [2:0]          ld_off,
  input  wdt_e                ld_wdt,
  input  logic                ld_sext,
  input  logic [DATA_W-1:0]   ld_raw,
  output logic [DATA_W-1:0]   ld_data
);

  logic [DATA_W-1:0] ld_sh;

  // Bytes and mask bits pushed past the top of the lane fall off.
  assign st_lane = st_data << {st_off, 3'b000};
  assign st_mask = base_mask(st_wdt) << st_off;

  assign ld_sh = ld_raw >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_sh;
    case (ld_wdt)
      Wdt8:    ld_data = {{(DATA_W-8){ld_sext & ld_sh[7]}}, ld_sh[7:0]};
      Wdt16:   ld_data = {{(DATA_W-16){ld_sext & ld_sh[15]}}, ld_sh[15:0]};
      Wdt32:   ld_data = {{(DATA_W-32){ld_sext & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access in flight between EXU, data memory and WBU.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned accesses into access errors.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [WdtW-1:0]     in_wdt_op,
  input  logic                in_sext,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [LsuMaskW-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err
);

  lsu_state_e          state;
  lsu_req_t            in_req;
  logic                illegal;
  logic [LsuDataW-1:0] st_lane;
  logic [LsuMaskW-1:0] st_mask;
  logic [LsuDataW-1:0] ld_data;

  // Load context kept for the response phase.
  logic [2:0]          ld_off_q;
  wdt_e                ld_wdt_q;
  logic                ld_sext_q;
  logic                ren_q;
  logic [LsuTagW-1:0]  tag_q;

  assign in_req.addr   = LsuAddrW'(in_addr);
  assign in_req.wdata  = LsuDataW'(in_wdata);
  assign in_req.ren    = in_ren;
  assign in_req.wen    = in_wen;
  assign in_req.wdt_op = wdt_e'(in_wdt_op);
  assign in_req.sext   = in_sext;
  assign in_req.tag    = LsuTagW'(in_tag);

  assign in_ready = (state == IDLE);

  always_comb begin
    illegal = (in_req.ren == in_req.wen);
`ifdef LSU_MISALIGN_TRAP_EN
    illegal = illegal | misaligned(in_req.addr[2:0], in_req.wdt_op);
`endif
  end

  lsu_lane_align #(
    .DATA_W (LsuDataW)
  ) u_lane (
    .st_off  (in_req.addr[2:0]),
    .st_data (in_req.wdata),
    .st_wdt  (in_req.wdt_op),
    .st_lane (st_lane),
    .st_mask (st_mask),
    .ld_off  (ld_off_q),
    .ld_wdt  (ld_wdt_q),
    .ld_sext (ld_sext_q),
    .ld_raw  (LsuDataW'(mem_rdata)),
    .ld_data (ld_data)
  );

  // Access FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_tag       <= '0;
      out_err       <= 1'b0;
      ld_off_q      <= '0;
      ld_wdt_q      <= Wdt8;
      ld_sext_q     <= 1'b0;
      ren_q         <= 1'b0;
      tag_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ld_off_q  <= in_req.addr[2:0];
            ld_wdt_q  <= in_req.wdt_op;
            ld_sext_q <= in_req.sext;
            ren_q     <= in_req.ren;
            tag_q     <= in_req.tag;
            if (illegal) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
              out_tag   <= TAG_W'(in_req.tag);
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= ADDR_W'({in_req.addr[LsuAddrW-1:3], 3'b000});
              mem_wen       <= in_req.wen;
              mem_wdata     <= in_req.wen ? DATA_W'(st_lane) : '0;
              mem_wmask     <= st_mask;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= ren_q ? DATA_W'(ld_data) : '0;
            out_tag   <= TAG_W'(tag_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed test-plan vectors, backpressure, illegal
// requests, a short random mix and reset while waiting on memory.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_addr, in_wdata;
  logic        in_ren, in_wen;
  logic [1:0]  in_wdt_op;
  logic        in_sext;
  logic [4:0]  in_tag;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
  logic [4:0]  out_tag;
  logic        out_err;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_done = 0;
  int          n_acc  = 0;
  logic [63:0] last_rdata, last_wdata;
  logic [7:0]  last_mask;
  logic        last_err;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ren(in_ren), .in_wen(in_wen), .in_wdt_op(in_wdt_op), .in_sext(in_sext), .in_tag(in_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_tag(out_tag), .out_err(out_err)
  );

  always @(posedge clk) if (rst_n && out_valid && out_ready) n_done <= n_done + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [2:0] off,
                                             input logic [1:0] wdt, input logic sext);
    logic [63:0] r;
    int nb;
    logic msb;
    nb = 1 << wdt;
    r  = '0;
    for (int i = 0; i < 8; i++)
      if (i < nb && int'(off) + i < 8) r[8*i +: 8] = raw[8*(int'(off)+i) +: 8];
    if (sext && wdt != 2'd3) begin
      msb = r[8*nb-1];
      for (int b = 8*nb; b < 64; b++) r[b] = msb;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_mask(input logic [2:0] off, input logic [1:0] wdt);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < (1 << wdt); i++)
      if (int'(off) + i < 8) m[int'(off)+i] = 1'b1;
    return m;
  endfunction

  function automatic logic model_illegal(input logic [2:0] off, input logic [1:0] wdt,
                                         input logic ren, input logic wen);
    logic bad;
    bad = (ren == wen);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(off) % (1 << wdt)) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  task automatic run_access(input logic [63:0] addr, input logic [63:0] wdata,
                            input logic ren, input logic wen, input logic [1:0] wdt,
                            input logic sext, input logic [4:0] tag, input logic [63:0] rdata,
                            input int req_stall, input int out_stall);
    exp_t e, got;
    logic [7:0]  emask;
    logic [63:0] ewdata, eaddr;
    e.err   = model_illegal(addr[2:0], wdt, ren, wen);
    e.rdata = (e.err || !ren) ? 64'h0 : model_load(rdata, addr[2:0], wdt, sext);
    e.tag   = tag;
    emask   = model_mask(addr[2:0], wdt);
    ewdata  = wen ? (wdata << (8 * int'(addr[2:0]))) : 64'h0;
    eaddr   = {addr[63:3], 3'b000};
    n_acc++;

    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_ren = ren; in_wen = wen;
    in_wdt_op = wdt; in_sext = sext; in_tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    if (e.err) begin
      chk("err_no_req", 64'(mem_req_valid), 64'd0);
      chk("err_lat", 64'(out_valid), 64'd1);
    end else begin
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_addr", mem_addr, eaddr);
      chk("req_wen", 64'(mem_wen), 64'(wen));
      chk("req_mask", 64'(mem_wmask), 64'(emask));
      chk("req_wdata", mem_wdata, ewdata);
      last_mask  = mem_wmask;
      last_wdata = mem_wdata;
      for (int k = 0; k < req_stall; k++) begin
        @(negedge clk);
        chk("req_hold_v", 64'(mem_req_valid), 64'd1);
        chk("req_hold_m", 64'(mem_wmask), 64'(emask));
        chk("req_hold_a", mem_addr, eaddr);
        chk("in_ready_busy", 64'(in_ready), 64'd0);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("req_drop", 64'(mem_req_valid), 64'd0);
      chk("wait_no_out", 64'(out_valid), 64'd0);
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("resp_lat", 64'(out_valid), 64'd1);
    end
    for (int k = 0; k < out_stall; k++) begin
      chk("out_hold_v", 64'(out_valid), 64'd1);
      chk("out_hold_d", out_rdata, e.rdata);
      chk("out_hold_rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_rdata", out_rdata, got.rdata);
      chk("out_err", 64'(out_err), 64'(got.err));
      chk("out_tag", 64'(out_tag), 64'(got.tag));
    end
    last_rdata = out_rdata;
    last_err   = out_err;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_ren = 1'b0; in_wen = 1'b0;
    in_wdt_op = 2'd0; in_sext = 1'b0; in_tag = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    last_rdata = '0; last_wdata = '0; last_mask = '0; last_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;

    // Signed byte load from the top half of the doubleword.
    run_access(64'h8000_0005, 64'h0, 1'b1, 1'b0, Wdt8, 1'b1, 5'd3,
               64'h0000_8000_0000_0000, 0, 0);
    chk("lb_sext_lit", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // Halfword store into the top lane.
    run_access(64'h8000_0006, 64'h1234, 1'b0, 1'b1, Wdt16, 1'b0, 5'd4, 64'hDEAD_BEEF, 0, 0);
    chk("sh_mask_lit", 64'(last_mask), 64'h00C0);
    chk("sh_wdata_lit", last_wdata, 64'h1234_0000_0000_0000);
    chk("sh_rdata_lit", last_rdata, 64'h0);

    // Memory and writeback backpressure.
    run_access(64'h8000_0004, 64'h0, 1'b1, 1'b0, Wdt32, 1'b1, 5'd7,
               64'h8765_4321_0000_0000, 3, 2);
    chk("bp_lit", last_rdata, 64'hFFFF_FFFF_8765_4321);

    // Widths and extension variants.
    run_access(64'h1000_0000, 64'h0, 1'b1, 1'b0, Wdt64, 1'b1, 5'd8, 64'hF000_0000_0000_0001, 0, 1);
    run_access(64'h1000_0002, 64'h0, 1'b1, 1'b0, Wdt16, 1'b0, 5'd9, 64'h0000_0000_ABCD_0000, 1, 0);

    // Misaligned word store.
    run_access(64'h8000_0002, 64'hDEAD_BEEF, 1'b0, 1'b1, Wdt32, 1'b0, 5'd10, 64'h0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err_lit", 64'(last_err), 64'd1);
`else
    chk("mis_mask_lit", 64'(last_mask), 64'h003C);
    chk("mis_noerr_lit", 64'(last_err), 64'd0);
`endif

    // Illegal opcode combinations.
    run_access(64'h2000_0000, 64'h55, 1'b1, 1'b1, Wdt8, 1'b0, 5'd11, 64'h0, 0, 1);
    chk("both_err_lit", 64'(last_err), 64'd1);
    run_access(64'h2000_0000, 64'h55, 1'b0, 1'b0, Wdt8, 1'b0, 5'd12, 64'h0, 0, 0);

    // Random aligned mix.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  w;
      logic [2:0]  off;
      logic        ld;
      w   = 2'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7));
      off = off & ~3'((1 << w) - 1);
      ld  = 1'($urandom_range(0, 1));
      run_access({32'h0, 32'h9000_0000} | 64'(off), {$urandom, $urandom}, ld, ~ld, w,
                 1'($urandom_range(0, 1)), 5'(i + 16), {$urandom, $urandom},
                 $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while waiting for memory, followed by a stale response.
    @(negedge clk);
    in_valid = 1'b1; in_addr = 64'h8000_0008; in_ren = 1'b1; in_wen = 1'b0;
    in_wdt_op = Wdt32; in_sext = 1'b0; in_tag = 5'd30;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_mem_addr", mem_addr, 64'd0);
    chk("arst_mem_wen", 64'(mem_wen), 64'd0);
    chk("arst_mem_wdata", mem_wdata, 64'd0);
    chk("arst_mem_mask", 64'(mem_wmask), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_rdata", out_rdata, 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    chk("arst_out_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stale_no_out", 64'(out_valid), 64'd0);
      chk("stale_idle", 64'(in_ready), 64'd1);
      @(negedge clk);
    end

    chk("completions", 64'(n_done), 64'(n_acc));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
